// File: rtl/bundler_stream.sv
// rtl/bundler_stream.sv - streaming majority-vote bundler for HDC hypervector slices
module bundler_stream #(
  parameter int NUM_HVS     = 17,
  parameter int PAR_BITS    = 10,
  parameter int HV_PER_BEAT = 4,
  parameter int TIE_MODE    = 0
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            clear,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [HV_PER_BEAT*PAR_BITS-1:0] in_bits,
  input  logic [PAR_BITS-1:0]             ties_1,
  input  logic [PAR_BITS-1:0]             ties_2,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PAR_BITS-1:0]             out_bits,
  output logic                            busy
);

  localparam int   NBEATS     = (NUM_HVS + HV_PER_BEAT - 1) / HV_PER_BEAT;
  localparam int   LAST_LANES = NUM_HVS - (NBEATS - 1) * HV_PER_BEAT;
  localparam int   CW         = $clog2(NUM_HVS + 1);
  localparam int   BW         = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int   HALF       = NUM_HVS / 2;
  localparam logic EVEN       = ((NUM_HVS % 2) == 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;

  if (TIE_MODE < 0 || TIE_MODE > 2) begin : g_bad_tie
    $error("bundler_stream: TIE_MODE must be 0, 1 or 2");
  end
  if (NUM_HVS < 1 || HV_PER_BEAT < 1 || HV_PER_BEAT > NUM_HVS) begin : g_bad_lanes
    $error("bundler_stream: need 1 <= HV_PER_BEAT <= NUM_HVS");
  end

  logic [1:0]          state;
  logic [BW-1:0]       beat;
  logic [CW-1:0]       counts   [PAR_BITS];
  logic [CW-1:0]       beat_pop [PAR_BITS];
  logic [CW-1:0]       total    [PAR_BITS];
  logic [PAR_BITS-1:0] tie_val;
  logic [PAR_BITS-1:0] vote;
  logic                accept;
  logic                last_beat;

  assign in_ready  = (state != S_EMIT);
  assign out_valid = (state == S_EMIT);
  assign busy      = (state == S_ACCUM);
  assign accept    = in_valid && in_ready;

  // With a single beat per bundle the IDLE beat is already the last one.
  assign last_beat = ((state == S_IDLE) && (NBEATS == 1)) ||
                     ((state == S_ACCUM) && (beat == BW'(NBEATS - 1)));

  always_comb begin
    for (int b = 0; b < PAR_BITS; b++) begin
      beat_pop[b] = '0;
      for (int k = 0; k < HV_PER_BEAT; k++) begin
        if (!last_beat || k < LAST_LANES) begin
          beat_pop[b] = beat_pop[b] + CW'(in_bits[k*PAR_BITS + b]);
        end
      end
    end
  end

  always_comb begin
    if (TIE_MODE == 1) begin
      tie_val = '0;
    end else if (TIE_MODE == 2) begin
      tie_val = '1;
    end else begin
      tie_val = ties_1 ^ ties_2;
    end
  end

  // counts is zero whenever the FSM is in IDLE, so the sum is also the load value.
  always_comb begin
    vote = '0;
    for (int b = 0; b < PAR_BITS; b++) begin
      total[b] = counts[b] + beat_pop[b];
      if (total[b] > CW'(HALF)) begin
        vote[b] = 1'b1;
      end else if (EVEN && total[b] == CW'(HALF)) begin
        vote[b] = tie_val[b];
      end else begin
        vote[b] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= S_IDLE;
      beat     <= '0;
      counts   <= '{default: '0};
      out_bits <= '0;
    end else if (clear) begin
      state  <= S_IDLE;
      beat   <= '0;
      counts <= '{default: '0};
    end else begin
      case (state)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            counts <= total;
            if (last_beat) begin
              state    <= S_EMIT;
              beat     <= '0;
              out_bits <= vote;
            end else begin
              state <= S_ACCUM;
              beat  <= beat + BW'(1);
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            state  <= S_IDLE;
            counts <= '{default: '0};
          end
        end
        default: begin
          state  <= S_IDLE;
          beat   <= '0;
          counts <= '{default: '0};
        end
      endcase
    end
  end

endmodule
